// File: rtl/stop_watch_ctrl_pkg.sv
// Shared definitions for the stop-watch front-end sequencer.
//   state_e     : FSM state encodings driven onto o_state
//   press_e     : the single button press acted on in a given cycle
//   pick_press  : resolves simultaneous presses (start/stop > lap > watch-reset)
//   is_running  : true in the states where the time counters advance
package stop_watch_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    PR_NONE = 2'd0,
    PR_SS   = 2'd1,
    PR_LAP  = 2'd2,
    PR_RST  = 2'd3
  } press_e;

  // Only the highest-priority press in a cycle is acted on; the others are dropped.
  function automatic press_e pick_press(input logic ss, input logic lap, input logic rst);
    press_e p;
    p = PR_NONE;
    if (ss) begin
      p = PR_SS;
    end else if (lap) begin
      p = PR_LAP;
    end else if (rst) begin
      p = PR_RST;
    end
    return p;
  endfunction

  function automatic logic is_running(input state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stop_watch_ctrl_btn_debounce.sv
// btn_debounce: conditions one raw push-button.
//   i_clk_h   : clock, rising edge
//   i_rst_h   : asynchronous active-high reset (clears sync, level, counter, pulse)
//   i_btn_h   : raw, asynchronous, bouncing button level
//   o_press_h : registered one-cycle pulse on a debounced 0->1 change
// Parameter DB_CYCLES (>= 1): consecutive cycles the synchronised input must
// differ from the debounced level before the level follows it.
// Raw edge to o_press_h is 2 (sync) + DB_CYCLES (debounce) + 1 (pulse) cycles.
module btn_debounce #(
  parameter int DB_CYCLES = 250_000
) (
  input  logic i_clk_h,
  input  logic i_rst_h,
  input  logic i_btn_h,
  output logic o_press_h
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the
  // debounced level; any agreeing cycle restarts the qualification window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_h or posedge i_rst_h) begin
    if (i_rst_h) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= i_btn_h;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign o_press_h = press_q;

endmodule

// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: front-end sequencer for the stop-watch datapath.
// Debounces the buttons, runs the IDLE/RUN/PAUSE(/LAP) FSM, generates the
// count-enable tick and the counter clear pulse.
// Optional feature: define STOP_WATCH_LAP_EN to build the lap button path and
// the LAP state; without it i_lap_h is ignored and o_disp_hold_h stays 0.
// Ports:
//   i_clk_h           in  clock, rising edge
//   i_sys_rst_h       in  asynchronous active-high system reset
//   i_start_stop_h    in  raw start/stop button
//   i_rst_watch_h     in  raw watch-reset button
//   i_lap_h           in  raw lap button
//   o_watch_running_h out high in RUN or LAP
//   o_watch_rst_h     out one-cycle clear pulse to the time counters
//   o_tick_en_h       out one-cycle count enable every TICK_DIV running cycles
//   o_disp_hold_h     out display freeze while in LAP
//   o_state           out FSM state (see stop_watch_ctrl_pkg::state_e)
// Parameters: CLK_HZ, TICK_HZ (TICK_DIV = CLK_HZ/TICK_HZ >= 2), DB_CYCLES (>= 1).
module stop_watch_ctrl
  import stop_watch_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 250_000
) (
  input  logic               i_clk_h,
  input  logic               i_sys_rst_h,
  input  logic               i_start_stop_h,
  input  logic               i_rst_watch_h,
  input  logic               i_lap_h,
  output logic               o_watch_running_h,
  output logic               o_watch_rst_h,
  output logic               o_tick_en_h,
  output logic               o_disp_hold_h,
  output logic [STATE_W-1:0] o_state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic ss_press, rst_press, lap_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .i_clk_h   (i_clk_h),
    .i_rst_h   (i_sys_rst_h),
    .i_btn_h   (i_start_stop_h),
    .o_press_h (ss_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .i_clk_h   (i_clk_h),
    .i_rst_h   (i_sys_rst_h),
    .i_btn_h   (i_rst_watch_h),
    .o_press_h (rst_press)
  );

`ifdef STOP_WATCH_LAP_EN
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .i_clk_h   (i_clk_h),
    .i_rst_h   (i_sys_rst_h),
    .i_btn_h   (i_lap_h),
    .o_press_h (lap_press)
  );
`else
  // Lap button has no consumer in this build; LAP is never entered.
  logic unused_lap;
  assign unused_lap = i_lap_h;
  assign lap_press  = 1'b0;
`endif

  state_e        state_q, state_d;
  press_e        press;
  logic [PW-1:0] presc_q, presc_d;
  logic          wrst_q, wrst_d;
  logic          tick_q, tick_d;
  logic          run_q, hold_q;

  assign press = pick_press(ss_press, lap_press, rst_press);

  always_comb begin
    state_d = state_q;
    wrst_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press == PR_SS) begin
          state_d = ST_RUN;
        end else if (press == PR_RST) begin
          wrst_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (press == PR_SS) begin
          state_d = ST_PAUSE;
        end else if (press == PR_LAP) begin
          state_d = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (press == PR_SS) begin
          state_d = ST_RUN;
        end else if (press == PR_RST) begin
          state_d = ST_IDLE;
          wrst_d  = 1'b1;
        end
      end
      ST_LAP: begin
        if (press == PR_SS) begin
          state_d = ST_PAUSE;
        end else if (press == PR_LAP) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler keeps its partial count across a pause so resuming does not
  // lose the fraction of a tick already elapsed; IDLE restarts it from zero.
  // The tick is registered, so it appears the cycle the prescaler wraps and
  // the first tick lands TICK_DIV cycles after entering RUN from IDLE.
  // Clear pulses only leave non-running states, so they never meet a tick.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (is_running(state_q)) begin
      tick_d  = (presc_q == PRESC_MAX);
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end else if (state_q == ST_IDLE) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge i_clk_h or posedge i_sys_rst_h) begin
    if (i_sys_rst_h) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      wrst_q  <= 1'b0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      wrst_q  <= wrst_d;
      tick_q  <= tick_d;
      run_q   <= is_running(state_d);
      hold_q  <= (state_d == ST_LAP);
    end
  end

  assign o_state           = state_q;
  assign o_watch_running_h = run_q;
  assign o_watch_rst_h     = wrst_q;
  assign o_tick_en_h       = tick_q;
  assign o_disp_hold_h     = hold_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Bench for stop_watch_ctrl with CLK_HZ=1000, TICK_HZ=100 (TICK_DIV=10),
// DB_CYCLES=4, so a held raw press changes o_state after 8 cycles.
// Expected tick cycles are pushed to exp_q as running cycles elapse and are
// popped by the tick monitor when o_tick_en_h fires.
module tb_stop_watch_ctrl;
  import stop_watch_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, ss, rw, lap;
  logic       running, wrst, tick, hold;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  logic [31:0] cyc = '0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  // Bench-side model of the FSM state and running-cycle phase (mod 10).
  logic [1:0] m_state;
  int         ph;

  stop_watch_ctrl #(
    .CLK_HZ    (1000),
    .TICK_HZ   (100),
    .DB_CYCLES (4)
  ) dut (
    .i_clk_h           (clk),
    .i_sys_rst_h       (rst),
    .i_start_stop_h    (ss),
    .i_rst_watch_h     (rw),
    .i_lap_h           (lap),
    .o_watch_running_h (running),
    .o_watch_rst_h     (wrst),
    .o_tick_en_h       (tick),
    .o_disp_hold_h     (hold),
    .o_state           (state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- tick scoreboard monitor ----------------
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tick_unexpected: tick at cycle %0d, none expected", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cyc !== mon_exp) begin
          bad++;
          $display("FAIL tick_cycle: tick at cycle %0d, expected cycle %0d", cyc, mon_exp);
        end
      end
      if (wrst === 1'b1) begin
        bad++;
        $display("FAIL tick_with_clear: got tick=1 wrst=1 at cycle %0d, expected not both", cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic m_running(input logic [1:0] s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

  // Wait n clock cycles, predicting the ticks produced on those edges.
  task automatic advance(input int n);
    for (int k = 0; k < n; k++) begin
      if (m_running(m_state)) begin
        ph = (ph + 1) % 10;
        if (ph == 0) exp_q.push_back(cyc + 1);
      end
      @(negedge clk);
    end
  endtask

  // Hold the given raw buttons long enough for one press and check the
  // resulting state exactly 8 cycles after the raw edge.
  task automatic do_press(input string name, input logic p_ss, input logic p_rw,
                          input logic p_lap, input logic [1:0] nxt, input logic exp_wrst);
    ss = p_ss; rw = p_rw; lap = p_lap;
    advance(7);
    total++;
    if (state !== m_state) begin
      bad++;
      $display("FAIL %s_early: state=%b after 7 cycles, expected %b", name, state, m_state);
    end
    advance(1);
    m_state = nxt;
    if (nxt == ST_IDLE) ph = 0;
    total++;
    if (state !== nxt) begin
      bad++;
      $display("FAIL %s_state: state=%b, expected %b", name, state, nxt);
    end
    total++;
    if (running !== m_running(nxt)) begin
      bad++;
      $display("FAIL %s_running: running=%b, expected %b", name, running, m_running(nxt));
    end
    total++;
    if (hold !== (nxt == ST_LAP)) begin
      bad++;
      $display("FAIL %s_hold: hold=%b, expected %b", name, hold, (nxt == ST_LAP));
    end
    total++;
    if (wrst !== exp_wrst) begin
      bad++;
      $display("FAIL %s_wrst: wrst=%b, expected %b", name, wrst, exp_wrst);
    end
    ss = 1'b0; rw = 1'b0; lap = 1'b0;
    advance(1);
    total++;
    if (wrst !== 1'b0) begin
      bad++;
      $display("FAIL %s_wrst_width: wrst=%b one cycle later, expected 0", name, wrst);
    end
    advance(7);
  endtask

  task automatic check_queue_empty(input string name);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_ticks: %0d expected ticks not seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ss = 1'b0; rw = 1'b0; lap = 1'b0;
    m_state = ST_IDLE; ph = 0;
    repeat (3) @(negedge clk);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL rst_state: state=%b, expected 00", state); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running: running=%b, expected 0", running); end
    total++; if (wrst !== 1'b0) begin bad++; $display("FAIL rst_wrst: wrst=%b, expected 0", wrst); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick: tick=%b, expected 0", tick); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL rst_hold: hold=%b, expected 0", hold); end
    rst = 1'b0;
    advance(5);
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL rst_idle_stays: state=%b, expected 00", state); end
  endtask

  task automatic test_debounce();
    // 3-cycle glitch is shorter than the debounce window.
    ss = 1'b1;
    advance(3);
    ss = 1'b0;
    advance(10);
    total++;
    if (state !== ST_IDLE) begin
      bad++;
      $display("FAIL bounce_ignored: state=%b, expected 00", state);
    end
    do_press("start", 1'b1, 1'b0, 1'b0, ST_RUN, 1'b0);
  endtask

  task automatic test_ticks_pause();
    int guard;
    advance(35);
    check_queue_empty("run35");
    // Pause so the prescaler holds 5: the pause press itself spans 8 running cycles.
    guard = 0;
    while (ph != 7 && guard < 20) begin
      advance(1);
      guard++;
    end
    do_press("pause", 1'b1, 1'b0, 1'b0, ST_PAUSE, 1'b0);
    advance(13);
    do_press("resume", 1'b1, 1'b0, 1'b0, ST_RUN, 1'b0);
    advance(12);
    check_queue_empty("resume");
  endtask

  task automatic test_rst_watch();
    do_press("rst_in_run", 1'b0, 1'b1, 1'b0, ST_RUN, 1'b0);
    do_press("pause2", 1'b1, 1'b0, 1'b0, ST_PAUSE, 1'b0);
    do_press("clear", 1'b0, 1'b1, 1'b0, ST_IDLE, 1'b1);
    do_press("restart", 1'b1, 1'b0, 1'b0, ST_RUN, 1'b0);
    advance(12);
    check_queue_empty("restart");
  endtask

  task automatic test_priority();
    do_press("pause3", 1'b1, 1'b0, 1'b0, ST_PAUSE, 1'b0);
    do_press("ss_and_rst", 1'b1, 1'b1, 1'b0, ST_RUN, 1'b0);
    advance(5);
    check_queue_empty("priority");
  endtask

  task automatic test_lap();
`ifdef STOP_WATCH_LAP_EN
    do_press("lap_enter", 1'b0, 1'b0, 1'b1, ST_LAP, 1'b0);
    advance(20);
    do_press("lap_rst_ignored", 1'b0, 1'b1, 1'b0, ST_LAP, 1'b0);
    do_press("lap_exit", 1'b0, 1'b0, 1'b1, ST_RUN, 1'b0);
    do_press("lap_enter2", 1'b0, 1'b0, 1'b1, ST_LAP, 1'b0);
    do_press("lap_to_pause", 1'b1, 1'b0, 1'b0, ST_PAUSE, 1'b0);
    do_press("lap_rst_pause", 1'b0, 1'b1, 1'b1, ST_PAUSE, 1'b0);
    do_press("lap_resume", 1'b1, 1'b0, 1'b0, ST_RUN, 1'b0);
`else
    do_press("lap_off1", 1'b0, 1'b0, 1'b1, ST_RUN, 1'b0);
    advance(10);
    do_press("lap_off2", 1'b0, 1'b0, 1'b1, ST_RUN, 1'b0);
`endif
    check_queue_empty("lap");
  endtask

  task automatic test_reset_mid_run();
    advance(13);
    #2;
    rst = 1'b1;
    ss  = 1'b1;
    #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL midrst_state: state=%b, expected 00", state); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL midrst_running: running=%b, expected 0", running); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL midrst_tick: tick=%b, expected 0", tick); end
    total++; if (wrst !== 1'b0) begin bad++; $display("FAIL midrst_wrst: wrst=%b, expected 0", wrst); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL midrst_hold: hold=%b, expected 0", hold); end
    m_state = ST_IDLE;
    ph = 0;
    check_queue_empty("midrst");
    repeat (3) @(negedge clk);
    // Start/stop held across reset release counts as a fresh press.
    rst = 1'b0;
    do_press("held_through_rst", 1'b1, 1'b0, 1'b0, ST_RUN, 1'b0);
    advance(12);
    check_queue_empty("held_through_rst");
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_ticks_pause();
    test_rst_watch();
    test_priority();
    test_lap();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
